// File: rtl/router_port_rx.sv
// router_port_rx: serial receiver for one router output port.
// Collects LSB-first payload bits into bytes, stages one byte so that the
// final byte of a packet can carry the last flag, and buffers {data, last, err}
// entries in a FIFO with registered head outputs on a valid/ready interface.
module router_port_rx #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frameo_n,
    input  logic        valido_n,
    input  logic        dout,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pkt_cnt,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Mask keeping only the lowest n bits of a partial byte.
    function automatic logic [7:0] low_mask(input logic [2:0] n);
        low_mask = (8'd1 << n) - 8'd1;
    endfunction

    // Receive-side state
    state_t      state_r, state_nxt;
    logic        frameo_q_r;
    logic [2:0]  bitcnt_r, bitcnt_nxt;
    logic [7:0]  shift_r, shift_nxt;
    logic [7:0]  staged_r, staged_nxt;
    logic        staged_v_r, staged_v_nxt;
    logic        tail_pend_r, tail_pend_nxt;
    logic        tail_err_r, tail_err_nxt;
    logic        term_done_r, term_done_nxt;
    logic        frame_seen_r, frame_seen_nxt;
    logic [15:0] pkt_cnt_r;
    logic        overflow_r;

    // Helpers for the bit captured on this edge
    logic [7:0]  cap_shift_s;
    logic [2:0]  cap_cnt_s;
    logic [7:0]  eff_shift_s;
    logic [2:0]  eff_cnt_s;
    logic        byte_done_s;

    // Push request towards the FIFO
    logic        push_req_s;
    logic [9:0]  push_entry_s;
    logic        push_ok_s;
    logic        pkt_inc_s;
    logic        ovf_set_s;

    // FIFO
    logic [9:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [AW:0]   count_r, count_nxt_s;
    logic          fifo_full_s;
    logic          pop_s;
    logic [9:0]    head_nxt_s;
    logic [7:0]    out_data_r;
    logic          out_last_r, out_err_r, out_valid_r;

    assign fifo_full_s = (count_r == FULL_COUNT);
    assign pop_s       = out_valid_r & out_ready;
    assign push_ok_s   = push_req_s & ~fifo_full_s;
    assign cap_cnt_s   = bitcnt_r + 3'd1;
    assign byte_done_s = ~valido_n & (bitcnt_r == 3'd7);
    assign eff_shift_s = valido_n ? shift_r : cap_shift_s;
    assign eff_cnt_s   = valido_n ? bitcnt_r : cap_cnt_s;

    // Shift register image with the current dout written at the bit position.
    always_comb begin
        cap_shift_s = shift_r;
        cap_shift_s[bitcnt_r] = dout;
    end

    // Receive FSM next-state, staging and push-request logic.
    always_comb begin
        state_nxt      = state_r;
        bitcnt_nxt     = bitcnt_r;
        shift_nxt      = shift_r;
        staged_nxt     = staged_r;
        staged_v_nxt   = staged_v_r;
        tail_pend_nxt  = tail_pend_r;
        tail_err_nxt   = tail_err_r;
        term_done_nxt  = term_done_r;
        frame_seen_nxt = frame_seen_r;
        push_req_s     = 1'b0;
        push_entry_s   = 10'd0;
        pkt_inc_s      = 1'b0;
        ovf_set_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!frameo_n && frameo_q_r) begin
                    state_nxt     = RECV;
                    staged_v_nxt  = 1'b0;
                    tail_pend_nxt = 1'b0;
                    tail_err_nxt  = 1'b0;
                    if (!valido_n) begin
                        shift_nxt  = {7'd0, dout};
                        bitcnt_nxt = 3'd1;
                    end else begin
                        shift_nxt  = 8'd0;
                        bitcnt_nxt = 3'd0;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            RECV: begin
                if (tail_pend_r) begin
                    // Second push of a two-push packet end; inputs are ignored.
                    push_req_s    = 1'b1;
                    push_entry_s  = {staged_r, 1'b1, tail_err_r};
                    pkt_inc_s     = ~tail_err_r;
                    tail_pend_nxt = 1'b0;
                    staged_v_nxt  = 1'b0;
                    state_nxt     = IDLE;
                end else if (!frameo_n) begin
                    if (byte_done_s) begin
                        push_req_s   = staged_v_r;
                        push_entry_s = {staged_r, 1'b0, 1'b0};
                        staged_nxt   = cap_shift_s;
                        staged_v_nxt = 1'b1;
                        shift_nxt    = 8'd0;
                        bitcnt_nxt   = 3'd0;
                    end else begin
                        shift_nxt  = eff_shift_s;
                        bitcnt_nxt = eff_cnt_s;
                    end
                end else begin
                    // End of frame; a bit on this edge is already folded in.
                    shift_nxt  = 8'd0;
                    bitcnt_nxt = 3'd0;
                    if (byte_done_s || (eff_cnt_s != 3'd0)) begin
                        if (byte_done_s) begin
                            staged_nxt   = cap_shift_s;
                            tail_err_nxt = 1'b0;
                        end else begin
                            staged_nxt   = eff_shift_s & low_mask(eff_cnt_s);
                            tail_err_nxt = 1'b1;
                        end
                        if (staged_v_r) begin
                            push_req_s    = 1'b1;
                            push_entry_s  = {staged_r, 1'b0, 1'b0};
                            staged_v_nxt  = 1'b1;
                            tail_pend_nxt = 1'b1;
                            state_nxt     = RECV;
                        end else begin
                            push_req_s   = 1'b1;
                            push_entry_s = {staged_nxt, 1'b1, tail_err_nxt};
                            pkt_inc_s    = ~tail_err_nxt;
                            staged_v_nxt = 1'b0;
                            state_nxt    = IDLE;
                        end
                    end else begin
                        push_req_s   = staged_v_r;
                        push_entry_s = {staged_r, 1'b1, 1'b0};
                        pkt_inc_s    = staged_v_r;
                        staged_v_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end
                end
            end
            DISCARD: begin
                push_req_s   = ~term_done_r;
                push_entry_s = {8'h00, 1'b1, 1'b1};
                if (!term_done_r && !fifo_full_s) begin
                    term_done_nxt = 1'b1;
                end else begin
                    term_done_nxt = term_done_r;
                end
                frame_seen_nxt = frame_seen_r | frameo_n;
                if (term_done_nxt && frame_seen_nxt) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DISCARD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A byte refused by a full FIFO is lost; drop the rest of the packet.
        if ((state_r == RECV) && push_req_s && fifo_full_s) begin
            ovf_set_s      = 1'b1;
            pkt_inc_s      = 1'b0;
            state_nxt      = DISCARD;
            staged_v_nxt   = 1'b0;
            tail_pend_nxt  = 1'b0;
            term_done_nxt  = 1'b0;
            frame_seen_nxt = 1'b0;
        end else begin
            ovf_set_s = 1'b0;
        end
    end

    // Receive-side registers, packet counter and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            frameo_q_r   <= 1'b1;
            bitcnt_r     <= 3'd0;
            shift_r      <= 8'd0;
            staged_r     <= 8'd0;
            staged_v_r   <= 1'b0;
            tail_pend_r  <= 1'b0;
            tail_err_r   <= 1'b0;
            term_done_r  <= 1'b0;
            frame_seen_r <= 1'b0;
            pkt_cnt_r    <= 16'd0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            frameo_q_r   <= frameo_n;
            bitcnt_r     <= bitcnt_nxt;
            shift_r      <= shift_nxt;
            staged_r     <= staged_nxt;
            staged_v_r   <= staged_v_nxt;
            tail_pend_r  <= tail_pend_nxt;
            tail_err_r   <= tail_err_nxt;
            term_done_r  <= term_done_nxt;
            frame_seen_r <= frame_seen_nxt;
            pkt_cnt_r    <= pkt_cnt_r + (pkt_inc_s ? 16'd1 : 16'd0);
            overflow_r   <= overflow_r | ovf_set_s;
        end
    end

    // Head entry after this edge; a push lands at the head only when the FIFO drains to it.
    always_comb begin
        rd_nxt_s    = rd_ptr_r + (pop_s ? AW'(1) : AW'(0));
        count_nxt_s = count_r + (AW + 1)'(push_ok_s) - (AW + 1)'(pop_s);
        if (push_ok_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = push_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // FIFO pointers, occupancy and registered head outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_last_r  <= 1'b0;
            out_err_r   <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_r + (push_ok_s ? AW'(1) : AW'(0));
            rd_ptr_r    <= rd_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            if (count_nxt_s != '0) begin
                {out_data_r, out_last_r, out_err_r} <= head_nxt_s;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_err   = out_err_r;
    assign out_valid = out_valid_r;
    assign pkt_cnt   = pkt_cnt_r;
    assign overflow  = overflow_r;

endmodule

// File: doc/router_port_rx.md
# router_port_rx

Downstream receiver for one router output port. Consumes the serial `dout[n]`, `frameo_n[n]` and `valido_n[n]` triple and assembles payload bits, LSB first, into bytes. Bytes are buffered in a FIFO of `{data, last, err}` entries and delivered over a valid/ready interface. One instance sits on each of the 16 output ports, between the router and the packet sink or scoreboard.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of 2, ≥2.
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: reset, synchronous, active-low; clock `clock`.
- `frameo_n` in 1: frame, active-low; high on or after the final bit.
- `valido_n` in 1: bit valid, active-low.
- `dout` in 1: serial payload bit.
- `out_data` out 8: head byte.
- `out_last` out 1: head entry ends its packet.
- `out_err` out 1: head entry is a partial byte or an overflow terminator.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head entry when `out_valid` is also high.
- `pkt_cnt` out 16: count of error-free packets delivered into the FIFO; wraps.
- `overflow` out 1: sticky; set when a byte is lost to a full FIFO.

## Operation
- All inputs are sampled at the rising edge. `frameo_q` holds the previous `frameo_n` and resets to 1.
- **Reset values:** state IDLE, FIFO empty, `out_valid`=0, `out_data`=0, `out_last`=0, `out_err`=0, `pkt_cnt`=0, `overflow`=0, bit count 0, staging register empty. A reset in the middle of a packet discards that packet completely; no terminator entry is written.
- **States:** IDLE, RECV, DISCARD.
- **IDLE → RECV:** on `frameo_n`=0 with `frameo_q`=1, i.e. a falling edge. A falling edge is required, so a mid-frame level never starts a packet. If `valido_n`=0 on the same edge, that bit is captured.
- **RECV:**
  - Each edge with `valido_n`=0 writes `dout` into `shift[bitcnt]` and increments the 3-bit `bitcnt`.
  - When the 8th bit of a byte is captured, the byte moves to a one-entry staging register. Any byte already staged is pushed first as `{byte, last=0, err=0}`.
  - Edges with `valido_n`=1 hold all state (gaps are legal).
- **End of frame:** the first RECV edge with `frameo_n`=1. A bit presented on that same edge with `valido_n`=0 is captured first and is the final bit.
  - `bitcnt`=0 and staging full: push `{staged, 1, 0}`, increment `pkt_cnt`.
  - `bitcnt`≠0: push the staged byte with last=0 if present, then push `{partial byte with upper bits zeroed, 1, 1}`. `pkt_cnt` is not incremented. When two pushes are needed they occur on consecutive edges; the block stays in RECV for one extra cycle and ignores the inputs during it.
  - No bits received: nothing is pushed.
  - The block then returns to IDLE.
- **Overflow:**
  - A push is rejected when the FIFO holds DEPTH entries. This applies even if a pop occurs on the same edge.
  - On rejection: the byte is dropped, `overflow` is set, and the state goes to DISCARD.
- **DISCARD:**
  - All inputs are ignored.
  - At the first edge with free space, push the terminator `{0x00, 1, 1}`.
  - Return to IDLE once the terminator has been pushed and `frameo_n`=1 has been seen since entering DISCARD.
- **Pop:**
  - A pop occurs on an edge where `out_valid`=1 and `out_ready`=1.
  - Pops are independent of the receive side.
  - A push and a pop may occur on the same edge whenever the push is legal.

## Timing
- The FIFO outputs are registered. `out_*` reflect the head entry and are stable while `out_valid`=1 and `out_ready`=0.
- A byte pushed at edge N produces `out_valid`=1 from cycle N+1 if the FIFO was empty.
- **Latency:** the final entry of a packet is pushed on the end-of-frame edge, or one edge later in the partial-byte case.
- **Throughput:** one pop per cycle; one push per cycle.
- `pkt_cnt` updates on the same edge as the `last` push.
- The pointers are log2(DEPTH) bits wide and wrap naturally. The occupancy counter is log2(DEPTH)+1 bits wide.

## Test plan
- **Two-byte packet, no gaps:** send 0xA5 then 0x3C, LSB first, `valido_n`=0 for 16 cycles, `frameo_n`=1 on the 16th bit, `out_ready`=1 → required entries {A5,0,0} then {3C,1,0}; `pkt_cnt`=1.
- **Valid gaps:** the same packet with `valido_n`=1 on every other cycle → identical entries; `out_valid` first rises one cycle after the 16th-bit edge.
- **Partial byte:** 11 bits = 0xFF then bits 1,0,1 → required entries {FF,0,0} then {05,1,1}; `pkt_cnt` unchanged.
- **Overflow, DEPTH=4:** `out_ready`=0, 6-byte packet 0x01..0x06 → FIFO holds 01..04; `overflow`=1; state DISCARD. Then raise `out_ready` → required pops 01,02,03,04, then {00,1,1}.
- **Empty frame:** `frameo_n` low for 3 cycles with `valido_n`=1 → no entry, `pkt_cnt`=0.
- **Reset mid-packet:** assert `reset_n`=0 for 1 cycle after 5 bits → all outputs at reset values. A following clean 1-byte packet 0x5A yields {5A,1,0}.
